// File: rtl/ctrl_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_decode_stage
// Brief    : RV32 decode stage with a two-entry valid/ready skid, flush,
//            illegal-opcode flag and a wrapping issued-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr_reg_fetch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [11:0]       cntrl_sig_decode,
    output logic [XLEN-1:0]   imm_o,
    output logic [4:0]        rd_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [2:0]        funct3_o,
    output logic              funct7b5_o,
    output logic              illegal_o,
    output logic [CNT_W-1:0]  insn_cnt
);

    localparam logic [6:0] c_OP_R     = 7'b0110011;
    localparam logic [6:0] c_OP_I     = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_JALR  = 7'b1100111;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC = 7'b0010111;

    localparam logic [11:0] c_CTRL_R     = 12'h401;
    localparam logic [11:0] c_CTRL_I     = 12'h403;
    localparam logic [11:0] c_CTRL_LOAD  = 12'h017;
    localparam logic [11:0] c_CTRL_STORE = 12'h00A;
    localparam logic [11:0] c_CTRL_BR    = 12'h420;
    localparam logic [11:0] c_CTRL_JAL   = 12'h041;
    localparam logic [11:0] c_CTRL_JALR  = 12'h083;
    localparam logic [11:0] c_CTRL_LUI   = 12'h103;
    localparam logic [11:0] c_CTRL_AUIPC = 12'h203;

    typedef struct packed {
        logic [11:0]     ctrl;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic            illegal;
    } dec_t;

    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm32;
    dec_t        w_dec;

    dec_t        r_out;
    dec_t        r_skid;
    logic        r_out_valid;
    logic        r_skid_valid;
    logic [CNT_W-1:0] r_cnt;

    logic        w_accept;
    logic        w_drain;

    assign w_imm_i = {{20{instr_reg_fetch[31]}}, instr_reg_fetch[31:20]};
    assign w_imm_s = {{20{instr_reg_fetch[31]}}, instr_reg_fetch[31:25],
                      instr_reg_fetch[11:7]};
    assign w_imm_b = {{19{instr_reg_fetch[31]}}, instr_reg_fetch[31],
                      instr_reg_fetch[7], instr_reg_fetch[30:25],
                      instr_reg_fetch[11:8], 1'b0};
    assign w_imm_j = {{11{instr_reg_fetch[31]}}, instr_reg_fetch[31],
                      instr_reg_fetch[19:12], instr_reg_fetch[20],
                      instr_reg_fetch[30:21], 1'b0};
    assign w_imm_u = {instr_reg_fetch[31:12], 12'h000};

    always_comb begin
        w_dec          = '0;
        w_imm32        = 32'h0;
        w_dec.rd       = instr_reg_fetch[11:7];
        w_dec.rs1      = instr_reg_fetch[19:15];
        w_dec.rs2      = instr_reg_fetch[24:20];
        w_dec.funct3   = instr_reg_fetch[14:12];
        w_dec.funct7b5 = instr_reg_fetch[30];
        case (instr_reg_fetch[6:0])
            c_OP_R:     begin w_dec.ctrl = c_CTRL_R; end
            c_OP_I:     begin w_dec.ctrl = c_CTRL_I;     w_imm32 = w_imm_i; end
            c_OP_LOAD:  begin w_dec.ctrl = c_CTRL_LOAD;  w_imm32 = w_imm_i; end
            c_OP_STORE: begin w_dec.ctrl = c_CTRL_STORE; w_imm32 = w_imm_s; end
            c_OP_BR:    begin w_dec.ctrl = c_CTRL_BR;    w_imm32 = w_imm_b; end
            c_OP_JAL:   begin w_dec.ctrl = c_CTRL_JAL;   w_imm32 = w_imm_j; end
            c_OP_JALR:  begin w_dec.ctrl = c_CTRL_JALR;  w_imm32 = w_imm_i; end
            c_OP_LUI:   begin w_dec.ctrl = c_CTRL_LUI;   w_imm32 = w_imm_u; end
            c_OP_AUIPC: begin w_dec.ctrl = c_CTRL_AUIPC; w_imm32 = w_imm_u; end
            default:    begin w_dec.illegal = 1'b1; end
        endcase
        // Widen to XLEN by sign-extending from bit 31 of the assembled value.
        w_dec.imm = XLEN'($signed(w_imm32));
    end

    // in_ready is taken straight from the skid occupancy flop.
    assign w_accept = in_valid && !r_skid_valid && !flush;
    assign w_drain  = r_out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out        <= '0;
            r_skid       <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_cnt        <= '0;
        end else begin
            if (w_drain) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (flush) begin
                r_out_valid  <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (!r_out_valid || w_drain) begin
                // Skid entry is older than anything presented now; no accept
                // can coincide with it because in_ready is low while it is held.
                if (r_skid_valid) begin
                    r_out        <= r_skid;
                    r_out_valid  <= 1'b1;
                    r_skid_valid <= 1'b0;
                end else if (w_accept) begin
                    r_out       <= w_dec;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_accept) begin
                r_skid       <= w_dec;
                r_skid_valid <= 1'b1;
            end
        end
    end

    assign in_ready         = !r_skid_valid;
    assign out_valid        = r_out_valid;
    assign cntrl_sig_decode = r_out.ctrl;
    assign imm_o            = r_out.imm;
    assign rd_o             = r_out.rd;
    assign rs1_o            = r_out.rs1;
    assign rs2_o            = r_out.rs2;
    assign funct3_o         = r_out.funct3;
    assign funct7b5_o       = r_out.funct7b5;
    assign illegal_o        = r_out.illegal;
    assign insn_cnt         = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_decode_stage
// Brief    : Randomised and directed bench for ctrl_decode_stage against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_decode_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr_reg_fetch;
    logic             out_valid;
    logic             out_ready;
    logic [11:0]      cntrl_sig_decode;
    logic [XLEN-1:0]  imm_o;
    logic [4:0]       rd_o;
    logic [4:0]       rs1_o;
    logic [4:0]       rs2_o;
    logic [2:0]       funct3_o;
    logic             funct7b5_o;
    logic             illegal_o;
    logic [CNT_W-1:0] insn_cnt;

    ctrl_decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .instr_reg_fetch  (instr_reg_fetch),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .cntrl_sig_decode (cntrl_sig_decode),
        .imm_o            (imm_o),
        .rd_o             (rd_o),
        .rs1_o            (rs1_o),
        .rs2_o            (rs2_o),
        .funct3_o         (funct3_o),
        .funct7b5_o       (funct7b5_o),
        .illegal_o        (illegal_o),
        .insn_cnt         (insn_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] ctrl;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic        f7b5;
        logic        illegal;
    } exp_t;

    exp_t q[$];
    int   m_cnt;
    int   n_checks;
    int   n_fail;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] ins);
        exp_t e;
        int   s;
        s          = int'($signed(ins));
        e.rd       = ins[11:7];
        e.rs1      = ins[19:15];
        e.rs2      = ins[24:20];
        e.funct3   = ins[14:12];
        e.f7b5     = ins[30];
        e.illegal  = 1'b0;
        e.imm      = 32'h0;
        case (ins[6:0])
            7'b0110011: e.ctrl = 12'h401;
            7'b0010011: begin e.ctrl = 12'h403; e.imm = 32'(s >>> 20); end
            7'b0000011: begin e.ctrl = 12'h017; e.imm = 32'(s >>> 20); end
            7'b0100011: begin e.ctrl = 12'h00A;
                e.imm = 32'(((s >>> 25) <<< 5) | int'(ins[11:7])); end
            7'b1100011: begin e.ctrl = 12'h420;
                e.imm = 32'(((s >>> 31) <<< 12) | (int'(ins[7]) << 11)
                      | (int'(ins[30:25]) << 5) | (int'(ins[11:8]) << 1)); end
            7'b1101111: begin e.ctrl = 12'h041;
                e.imm = 32'(((s >>> 31) <<< 20) | (int'(ins[19:12]) << 12)
                      | (int'(ins[20]) << 11) | (int'(ins[30:21]) << 1)); end
            7'b1100111: begin e.ctrl = 12'h083; e.imm = 32'(s >>> 20); end
            7'b0110111: begin e.ctrl = 12'h103; e.imm = ins & 32'hFFFFF000; end
            7'b0010111: begin e.ctrl = 12'h203; e.imm = ins & 32'hFFFFF000; end
            default:    begin e.ctrl = 12'h000; e.illegal = 1'b1; end
        endcase
        return e;
    endfunction

    // One clock: drive, compare model against DUT at negedge, advance model.
    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [31:0] ins, input logic ordy, output logic acc);
        int sz;
        rst = r; flush = f; in_valid = iv; instr_reg_fetch = ins; out_ready = ordy;
        @(negedge clk);
        sz = q.size();
        check("in_ready", in_ready, sz < 2);
        check("out_valid", out_valid, sz > 0);
        check("insn_cnt", insn_cnt, m_cnt % (1 << CNT_W));
        if (sz > 0) begin
            check("ctrl", cntrl_sig_decode, q[0].ctrl);
            check("imm", imm_o, q[0].imm);
            check("rd", rd_o, q[0].rd);
            check("rs1", rs1_o, q[0].rs1);
            check("rs2", rs2_o, q[0].rs2);
            check("funct3", funct3_o, q[0].funct3);
            check("funct7b5", funct7b5_o, q[0].f7b5);
            check("illegal", illegal_o, q[0].illegal);
        end
        @(posedge clk);
        acc = 1'b0;
        if (r) begin
            q.delete();
            m_cnt = 0;
        end else begin
            if (sz > 0 && ordy) begin
                m_cnt++;
                void'(q.pop_front());
            end
            if (f) begin
                q.delete();
            end else if (iv && sz < 2) begin
                q.push_back(ref_decode(ins));
                acc = 1'b1;
            end
        end
        #1;
    endtask

    task automatic reset_check(input string tag);
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_valid"}, out_valid, 1'b0);
        check({tag, "_ready"}, in_ready, 1'b1);
        check({tag, "_ctrl"}, cntrl_sig_decode, 12'h0);
        check({tag, "_imm"}, imm_o, 32'h0);
        check({tag, "_fields"}, {rd_o, rs1_o, rs2_o, funct3_o, funct7b5_o}, 19'h0);
        check({tag, "_illegal"}, illegal_o, 1'b0);
        check({tag, "_cnt"}, insn_cnt, 4'h0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [10];
        logic [31:0] w;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
        w = $urandom;
        if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 9)];
        return w;
    endfunction

    logic        acc;
    logic [31:0] bp [4];

    initial begin
        n_checks = 0; n_fail = 0; m_cnt = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr_reg_fetch = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        reset_check("reset");

        // Single issue
        step(0, 0, 1, 32'h00A00093, 1, acc);
        check("single_ctrl", cntrl_sig_decode, 12'h403);
        check("single_imm", imm_o, 32'h0000000A);
        check("single_rd", rd_o, 5'd1);
        step(0, 0, 0, 32'h0, 1, acc);
        check("single_cnt", insn_cnt, 4'd1);

        // Class sweep, one per cycle
        step(0, 0, 1, 32'h002081B3, 1, acc);
        step(0, 0, 1, 32'h00812283, 1, acc);
        check("sweep_load_ctrl", cntrl_sig_decode, 12'h017);
        step(0, 0, 1, 32'hFE208EE3, 1, acc);
        check("sweep_br_imm", imm_o, 32'hFFFFFFFC);
        step(0, 0, 0, 32'h0, 1, acc);
        check("sweep_cnt", insn_cnt, 4'd4);

        // Illegal opcodes still handshake
        step(0, 0, 1, 32'h0000007F, 1, acc);
        check("illegal_flag", illegal_o, 1'b1);
        step(0, 0, 1, 32'h00000000, 1, acc);
        step(0, 0, 0, 32'h0, 1, acc);
        check("illegal_cnt", insn_cnt, 4'd6);

        // Backpressure: four instructions, consumer stalled three cycles
        bp = '{32'h00100113, 32'h00312023, 32'h123450B7, 32'h008000EF};
        for (int i = 0, c = 0; i < 4 && c < 40; c++) begin
            step(0, 0, 1, bp[i], c >= 3, acc);
            if (acc) i++;
        end
        repeat (3) step(0, 0, 0, 32'h0, 1, acc);

        // Flush with the skid full and a new instruction presented
        step(0, 0, 1, 32'h00500193, 0, acc);
        step(0, 0, 1, 32'h00600213, 0, acc);
        step(0, 0, 1, 32'h00700293, 0, acc);
        step(0, 1, 1, 32'h00800313, 0, acc);
        check("flush_valid", out_valid, 1'b0);
        check("flush_ready", in_ready, 1'b1);
        step(0, 0, 0, 32'h0, 1, acc);

        // Counter wrap: 17 issues after reset
        step(1, 0, 0, 32'h0, 0, acc);
        reset_check("reset2");
        for (int i = 0; i < 17; i++) step(0, 0, 1, rand_instr(), 1, acc);
        step(0, 0, 0, 32'h0, 1, acc);
        check("wrap_cnt", insn_cnt, 4'd1);

        // Reset while holding a valid output
        step(0, 0, 1, 32'h00A00093, 0, acc);
        step(0, 0, 1, 32'h00B00093, 0, acc);
        check("pre_reset_valid", out_valid, 1'b1);
        step(1, 0, 1, 32'h00C00093, 0, acc);
        reset_check("midreset");

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 9) < 7), rand_instr(),
                 ($urandom_range(0, 9) < 6), acc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
